// File: rtl/interrupt_controller_if.sv
// Signal bundle between the interrupt controller, its peripheral sources and the core.
// The master modport is the controller's view; the slave modport is the environment's view.
interface interrupt_controller_if #(
  parameter int N = 16
);
  logic [N-1:0] int_req_i;
  logic [N-1:0] mie_i;
  logic         int_rst_i;
  logic         int_o;
  logic [31:0]  mcause_o;
  logic [N-1:0] int_fin_o;

  modport master (
    input  int_req_i,
    input  mie_i,
    input  int_rst_i,
    output int_o,
    output mcause_o,
    output int_fin_o
  );

  modport slave (
    output int_req_i,
    output mie_i,
    output int_rst_i,
    input  int_o,
    input  mcause_o,
    input  int_fin_o
  );
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority (index 0 highest) interrupt controller: one interrupt in service at a time,
// one-cycle pulse to the core, one-cycle one-hot acknowledge back to the serviced source.
module interrupt_controller #(
  parameter int N = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  interrupt_controller_if.master  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           int_q, int_d;
  logic [31:0]    mcause_q, mcause_d;
  logic [N-1:0]   fin_q, fin_d;

  logic [N-1:0]   pend_s;
  logic [IW-1:0]  win_s;
  logic           any_s;

  // Lowest set index of the enabled requests wins; scanning downward lets it overwrite last.
  always_comb begin
    pend_s = bus.int_req_i & bus.mie_i;
    win_s  = {IW{1'b0}};
    any_s  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_s[i]) begin
        win_s = IW'(i);
        any_s = 1'b1;
      end else begin
        any_s = any_s;
      end
    end
  end

  // Next-state and next-output logic; mcause and idx are held unless a new service starts.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    int_d    = 1'b0;
    mcause_d = mcause_q;
    fin_d    = {N{1'b0}};
    case (state_q)
      IDLE: begin
        if (any_s) begin
          idx_d    = win_s;
          int_d    = 1'b1;
          mcause_d = 32'h8000_0010 + {{(32 - IW){1'b0}}, win_s};
          state_d  = BUSY;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        if (bus.int_rst_i) begin
          fin_d[idx_q] = 1'b1;
          state_d      = FIN;
        end else begin
          state_d      = BUSY;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any service without an acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= {IW{1'b0}};
      int_q    <= 1'b0;
      mcause_q <= 32'h0000_0000;
      fin_q    <= {N{1'b0}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      int_q    <= int_d;
      mcause_q <= mcause_d;
      fin_q    <= fin_d;
    end
  end

  assign bus.int_o     = int_q;
  assign bus.mcause_o  = mcause_q;
  assign bus.int_fin_o = fin_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: vector table, directed corner sequences, then randomized
// traffic against a transaction-level reference model.
module tb_interrupt_controller;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interrupt_controller_if #(.N(N)) bus ();

  interrupt_controller #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a service is either absent, awaiting the handler end, or being acknowledged.
  bit          in_service = 1'b0;
  bit          acking     = 1'b0;
  int          svc_idx    = 0;
  logic        m_int      = 1'b0;
  logic [31:0] m_cause    = 32'h0;
  logic [15:0] m_fin      = 16'h0;

  typedef struct {
    logic [15:0] req;
    logic [15:0] mie;
    logic        rst;
    logic        irst;
    logic        e_int;
    logic [31:0] e_cause;
    logic [15:0] e_fin;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [15:0] req, input logic [15:0] mie,
                            input logic r, input logic irst);
    int winner;
    if (r) begin
      in_service = 1'b0; acking = 1'b0; svc_idx = 0;
      m_int = 1'b0; m_cause = 32'h0; m_fin = 16'h0;
    end else if (acking) begin
      acking = 1'b0; m_int = 1'b0; m_fin = 16'h0;
    end else if (in_service) begin
      m_int = 1'b0;
      if (irst) begin
        m_fin = 16'h0;
        m_fin[svc_idx] = 1'b1;
        acking = 1'b1;
        in_service = 1'b0;
      end
    end else begin
      winner = -1;
      for (int i = 0; i < N; i++)
        if (winner < 0 && req[i] && mie[i]) winner = i;
      if (winner >= 0) begin
        svc_idx = winner;
        in_service = 1'b1;
        m_int = 1'b1;
        m_cause = 32'h8000_0010 + 32'(winner);
      end else begin
        m_int = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs while clk is low, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [15:0] req, input logic [15:0] mie,
                      input logic r, input logic irst);
    @(negedge clk);
    rst = r;
    bus.int_req_i = req;
    bus.mie_i = mie;
    bus.int_rst_i = irst;
    model_edge(req, mie, r, irst);
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string name, input logic e_int, input logic [31:0] e_cause,
                      input logic [15:0] e_fin);
    chk({name, ".int_o"}, {31'd0, bus.int_o}, {31'd0, e_int});
    chk({name, ".mcause_o"}, bus.mcause_o, e_cause);
    chk({name, ".int_fin_o"}, {16'd0, bus.int_fin_o}, {16'd0, e_fin});
  endtask

  logic [15:0] src_req;
  logic [15:0] rmie;
  logic        rrst;
  logic        rirst;

  initial begin
    bus.int_req_i = 16'h0;
    bus.mie_i     = 16'h0;
    bus.int_rst_i = 1'b0;

    //          req       mie       rst   irst  int   cause           fin
    vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h0,          16'h0};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h0,          16'h0};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h0,          16'h0};
    vecs[3]  = '{16'h0020, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'h8000_0015, 16'h0};
    vecs[4]  = '{16'h0020, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    vecs[5]  = '{16'h0020, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    vecs[6]  = '{16'h0020, 16'hFFFF, 1'b0, 1'b1, 1'b0, 32'h8000_0015, 16'h0020};
    vecs[7]  = '{16'h0020, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    vecs[8]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    vecs[9]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0015, 16'h0};
    vecs[10] = '{16'h0208, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'h8000_0013, 16'h0};
    vecs[11] = '{16'h0208, 16'hFFFF, 1'b0, 1'b1, 1'b0, 32'h8000_0013, 16'h0008};
    vecs[12] = '{16'h0208, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0013, 16'h0};
    vecs[13] = '{16'h0200, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'h8000_0019, 16'h0};
    vecs[14] = '{16'h0200, 16'hFFFF, 1'b0, 1'b1, 1'b0, 32'h8000_0019, 16'h0200};
    vecs[15] = '{16'h0200, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0019, 16'h0};
    vecs[16] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h8000_0019, 16'h0};

    for (int v = 0; v < 17; v++) begin
      step(vecs[v].req, vecs[v].mie, vecs[v].rst, vecs[v].irst);
      chk3($sformatf("vec%0d", v), vecs[v].e_int, vecs[v].e_cause, vecs[v].e_fin);
    end

    // Masked request stays silent, then fires on the first edge after unmasking.
    for (int c = 0; c < 20; c++) begin
      step(16'h0004, 16'hFFFB, 1'b0, 1'b0);
      chk("mask.int_o", {31'd0, bus.int_o}, 32'd0);
    end
    step(16'h0004, 16'hFFFF, 1'b0, 1'b0); chk3("mask.fire", 1'b1, 32'h8000_0012, 16'h0);
    step(16'h0004, 16'hFFFF, 1'b0, 1'b1); chk3("mask.fin", 1'b0, 32'h8000_0012, 16'h0004);
    step(16'h0004, 16'hFFFF, 1'b0, 1'b0); chk3("mask.done", 1'b0, 32'h8000_0012, 16'h0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0); chk3("mask.idle", 1'b0, 32'h8000_0012, 16'h0);

    // Higher-priority source 0 arrives mid-service of source 7 and must wait.
    step(16'h0080, 16'hFFFF, 1'b0, 1'b0); chk3("nopre.s7", 1'b1, 32'h8000_0017, 16'h0);
    for (int c = 0; c < 4; c++) begin
      step(16'h0081, 16'hFFFF, 1'b0, 1'b0); chk3("nopre.hold", 1'b0, 32'h8000_0017, 16'h0);
    end
    step(16'h0081, 16'hFFFF, 1'b0, 1'b1); chk3("nopre.fin7", 1'b0, 32'h8000_0017, 16'h0080);
    step(16'h0081, 16'hFFFF, 1'b0, 1'b0); chk3("nopre.back", 1'b0, 32'h8000_0017, 16'h0);
    step(16'h0001, 16'hFFFF, 1'b0, 1'b0); chk3("nopre.s0", 1'b1, 32'h8000_0010, 16'h0);
    step(16'h0001, 16'hFFFF, 1'b0, 1'b1); chk3("nopre.fin0", 1'b0, 32'h8000_0010, 16'h0001);
    step(16'h0001, 16'hFFFF, 1'b0, 1'b0); chk3("nopre.done", 1'b0, 32'h8000_0010, 16'h0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0); chk3("nopre.idle", 1'b0, 32'h8000_0010, 16'h0);

    // Reset mid-service drops the service silently; the held request is re-taken,
    // and int_rst in the very cycle int_o is high is honoured.
    step(16'h0010, 16'hFFFF, 1'b0, 1'b0); chk3("rstmid.s4", 1'b1, 32'h8000_0014, 16'h0);
    step(16'h0010, 16'hFFFF, 1'b1, 1'b1); chk3("rstmid.rst", 1'b0, 32'h0, 16'h0);
    step(16'h0010, 16'hFFFF, 1'b0, 1'b0); chk3("rstmid.again", 1'b1, 32'h8000_0014, 16'h0);
    step(16'h0010, 16'hFFFF, 1'b0, 1'b1); chk3("rstmid.fin", 1'b0, 32'h8000_0014, 16'h0010);
    step(16'h0010, 16'hFFFF, 1'b0, 1'b0); chk3("rstmid.done", 1'b0, 32'h8000_0014, 16'h0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0); chk3("rstmid.idle", 1'b0, 32'h8000_0014, 16'h0);

    // Randomized traffic: sources hold requests until acknowledged.
    src_req = 16'h0;
    rmie = 16'hFFFF;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!src_req[i] && $urandom_range(15, 0) == 0) src_req[i] = 1'b1;
      if ($urandom_range(7, 0) == 0) rmie = 16'($urandom) | 16'($urandom);
      rirst = ($urandom_range(3, 0) == 0);
      rrst  = ($urandom_range(199, 0) == 0);
      step(src_req, rmie, rrst, rirst);
      chk3("rand", m_int, m_cause, m_fin);
      chk("rand.fin_onehot", {31'd0, $onehot0(bus.int_fin_o)}, 32'd1);
      src_req = src_req & ~bus.int_fin_o;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
